mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : shares the unified memory bus between fetch and load/store
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                i_reset,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_ack,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_mem_req,
   input  logic                i_mem_we,
   input  logic [ADDR_W-1:0]   i_mem_addr,
   input  logic [DATA_W-1:0]   i_mem_wdata,
   input  logic [DATA_W/8-1:0] i_mem_wstrb,
   output logic                o_mem_ack,
   output logic [DATA_W-1:0]   o_mem_rdata,
   output logic                o_bus_en,
   output logic                o_bus_we,
   output logic [ADDR_W-1:0]   o_bus_addr,
   output logic [DATA_W-1:0]   o_bus_wdata,
   output logic [DATA_W/8-1:0] o_bus_wstrb,
   input  logic [DATA_W-1:0]   i_bus_rdata,
   output logic                o_hold_if,
   output logic                o_hold_mem
);

   localparam int WAIT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(MEM_LATENCY - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic [0:0]          state;
   logic                owner_mem;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                grant_mem;
   logic                grant_if;

   // MEM wins unless IF has already watched STARVE_LIMIT MEM grants go by
   assign grant_mem = i_mem_req & ~(i_if_req & (starve_cnt == STARVE_MAX));
   assign grant_if  = i_if_req & ~grant_mem;

   assign o_hold_if  = i_if_req & ~o_if_ack;
   assign o_hold_mem = i_mem_req & ~o_mem_ack;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= IDLE;
         owner_mem   <= 1'b0;
         wait_cnt    <= '0;
         starve_cnt  <= '0;
         o_bus_en    <= 1'b0;
         o_bus_we    <= 1'b0;
         o_bus_addr  <= '0;
         o_bus_wdata <= '0;
         o_bus_wstrb <= '0;
         o_if_ack    <= 1'b0;
         o_mem_ack   <= 1'b0;
         o_if_rdata  <= '0;
         o_mem_rdata <= '0;
      end else begin
         o_if_ack  <= 1'b0;
         o_mem_ack <= 1'b0;
         if (!i_if_req) begin
            starve_cnt <= '0;
         end
         case (state)
            IDLE: begin
               if (grant_mem) begin
                  owner_mem   <= 1'b1;
                  o_bus_en    <= 1'b1;
                  o_bus_we    <= i_mem_we;
                  o_bus_addr  <= i_mem_addr;
                  o_bus_wdata <= i_mem_wdata;
                  o_bus_wstrb <= i_mem_we ? i_mem_wstrb : '0;
                  wait_cnt    <= WAIT_INIT;
                  state       <= ACCESS;
                  if (i_if_req && (starve_cnt != STARVE_MAX)) begin
                     starve_cnt <= starve_cnt + STARVE_W'(1);
                  end
               end else if (grant_if) begin
                  owner_mem   <= 1'b0;
                  o_bus_en    <= 1'b1;
                  o_bus_we    <= 1'b0;
                  o_bus_addr  <= i_if_addr;
                  o_bus_wdata <= '0;
                  o_bus_wstrb <= '0;
                  wait_cnt    <= WAIT_INIT;
                  starve_cnt  <= '0;
                  state       <= ACCESS;
               end
            end
            default: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end else begin
                  // Last access cycle: read data is valid on the bus now
                  if (owner_mem) begin
                     o_mem_ack <= 1'b1;
                     if (!o_bus_we) begin
                        o_mem_rdata <= i_bus_rdata;
                     end
                  end else begin
                     o_if_ack   <= 1'b1;
                     o_if_rdata <= i_bus_rdata;
                  end
                  o_bus_en    <= 1'b0;
                  o_bus_we    <= 1'b0;
                  o_bus_wstrb <= '0;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : scoreboard bench for mem_bus_arbiter (latency 2 and 1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        if_ack, mem_ack, bus_en, bus_we, hold_if, hold_mem;
   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   logic        d1_if_req, d1_mem_req, d1_mem_we;
   logic [31:0] d1_if_addr, d1_mem_addr, d1_mem_wdata;
   logic [3:0]  d1_mem_wstrb;
   logic        d1_if_ack, d1_mem_ack, d1_bus_en, d1_bus_we, d1_hold_if, d1_hold_mem;
   logic [31:0] d1_if_rdata, d1_mem_rdata, d1_bus_addr, d1_bus_wdata, d1_bus_rdata;
   logic [3:0]  d1_bus_wstrb;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model(input logic [31:0] a);
      if (a == 32'h100) return 32'h0000_0013;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign bus_rdata    = (bus_en && !bus_we) ? model(bus_addr) : 32'h0;
   assign d1_bus_rdata = (d1_bus_en && !d1_bus_we) ? model(d1_bus_addr) : 32'h0;

   mem_bus_arbiter dut (
      .i_clk(clk), .i_reset(reset),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
      .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
      .i_mem_wdata(mem_wdata), .i_mem_wstrb(mem_wstrb),
      .o_mem_ack(mem_ack), .o_mem_rdata(mem_rdata),
      .o_bus_en(bus_en), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
      .o_bus_wdata(bus_wdata), .o_bus_wstrb(bus_wstrb), .i_bus_rdata(bus_rdata),
      .o_hold_if(hold_if), .o_hold_mem(hold_mem)
   );

   mem_bus_arbiter #(.MEM_LATENCY(1)) dut1 (
      .i_clk(clk), .i_reset(reset),
      .i_if_req(d1_if_req), .i_if_addr(d1_if_addr), .o_if_ack(d1_if_ack), .o_if_rdata(d1_if_rdata),
      .i_mem_req(d1_mem_req), .i_mem_we(d1_mem_we), .i_mem_addr(d1_mem_addr),
      .i_mem_wdata(d1_mem_wdata), .i_mem_wstrb(d1_mem_wstrb),
      .o_mem_ack(d1_mem_ack), .o_mem_rdata(d1_mem_rdata),
      .o_bus_en(d1_bus_en), .o_bus_we(d1_bus_we), .o_bus_addr(d1_bus_addr),
      .o_bus_wdata(d1_bus_wdata), .o_bus_wstrb(d1_bus_wstrb), .i_bus_rdata(d1_bus_rdata),
      .o_hold_if(d1_hold_if), .o_hold_mem(d1_hold_mem)
   );

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t if_q[$];
   exp_t mem_q[$];
   exp_t d1_q[$];

   // Scoreboard: every ack must match the oldest expectation for that requester
   always @(negedge clk) begin : monitor
      exp_t e;
      if (if_ack) begin
         checks++;
         if (if_q.size() == 0 || mem_ack) begin
            errors++;
            $display("FAIL if_ack_unexpected cyc %0d mem_ack %b required no ack", cyc, mem_ack);
         end else begin
            e = if_q.pop_front();
            if (if_rdata !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL if_ack rdata %h cyc %0d required rdata %h cyc %0d",
                        if_rdata, cyc, e.data, e.cyc);
            end
         end
      end
      if (mem_ack) begin
         checks++;
         if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL mem_ack_unexpected cyc %0d required no ack", cyc);
         end else begin
            e = mem_q.pop_front();
            if (mem_rdata !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL mem_ack rdata %h cyc %0d required rdata %h cyc %0d",
                        mem_rdata, cyc, e.data, e.cyc);
            end
         end
      end
      if (d1_if_ack) begin
         checks++;
         if (d1_q.size() == 0) begin
            errors++;
            $display("FAIL d1_if_ack_unexpected cyc %0d required no ack", cyc);
         end else begin
            e = d1_q.pop_front();
            if (d1_if_rdata !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL d1_if_ack rdata %h cyc %0d required rdata %h cyc %0d",
                        d1_if_rdata, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
      d1_if_req = 0; d1_if_addr = 0; d1_mem_req = 0; d1_mem_we = 0;
      d1_mem_addr = 0; d1_mem_wdata = 0; d1_mem_wstrb = 0;
      repeat (2) tick();
      checks++;
      if ({bus_en, bus_we, bus_addr, bus_wdata, bus_wstrb, if_ack, mem_ack,
           if_rdata, mem_rdata, hold_if, hold_mem, d1_bus_en, d1_if_ack} !== '0) begin
         errors++;
         $display("FAIL reset_state bus_en %b addr %h ack %b/%b rdata %h/%h required all zero",
                  bus_en, bus_addr, if_ack, mem_ack, if_rdata, mem_rdata);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_if_read();
      int n = cyc;
      if_addr = 32'h100; if_req = 1'b1;
      if_q.push_back('{32'h0000_0013, n + 3});
      #1;
      checks++;
      if (hold_if !== 1'b1) begin
         errors++; $display("FAIL if_read_hold_start hold_if %b required 1", hold_if);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (k < 3) begin
            if (bus_en !== 1'b1 || bus_addr !== 32'h100 || bus_we !== 1'b0 ||
                bus_wstrb !== 4'h0 || hold_if !== 1'b1) begin
               errors++;
               $display("FAIL if_read_bus k %0d en %b addr %h we %b hold %b required 1 00000100 0 1",
                        k, bus_en, bus_addr, bus_we, hold_if);
            end
         end else if (bus_en !== 1'b0 || hold_if !== 1'b0 || if_ack !== 1'b1) begin
            errors++;
            $display("FAIL if_read_ack en %b hold %b ack %b required 0 0 1", bus_en, hold_if, if_ack);
         end
      end
      if_req = 1'b0;
      tick();
      checks++;
      if (if_rdata !== 32'h13 || if_ack !== 1'b0) begin
         errors++; $display("FAIL if_rdata_held rdata %h ack %b required 00000013 0", if_rdata, if_ack);
      end
   endtask

   task automatic test_simultaneous();
      int n = cyc;
      if_addr = 32'h104; if_req = 1'b1;
      mem_we = 1'b0; mem_addr = 32'h2000; mem_wstrb = 4'hF; mem_req = 1'b1;
      mem_q.push_back('{model(32'h2000), n + 3});
      if_q.push_back('{model(32'h104), n + 6});
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            checks++;
            if (bus_addr !== 32'h2000 || bus_we !== 1'b0 || bus_wstrb !== 4'h0) begin
               errors++;
               $display("FAIL simul_mem_first addr %h we %b wstrb %h required 00002000 0 0",
                        bus_addr, bus_we, bus_wstrb);
            end
         end
         if (k == 3) mem_req = 1'b0;
         if (k == 4) begin
            checks++;
            if (bus_en !== 1'b1 || bus_addr !== 32'h104) begin
               errors++;
               $display("FAIL simul_if_second en %b addr %h required 1 00000104", bus_en, bus_addr);
            end
         end
         if (k == 6) if_req = 1'b0;
      end
      tick();
   endtask

   task automatic test_store();
      int n = cyc;
      mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF; mem_req = 1'b1;
      mem_q.push_back('{model(32'h2000), n + 3});
      #1;
      checks++;
      if (hold_mem !== 1'b1) begin
         errors++; $display("FAIL store_hold_start hold_mem %b required 1", hold_mem);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (k < 3) begin
            if (bus_en !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h2000 ||
                bus_wdata !== 32'hDEAD_BEEF || bus_wstrb !== 4'hF) begin
               errors++;
               $display("FAIL store_bus k %0d en %b we %b addr %h wdata %h wstrb %h required 1 1 00002000 deadbeef f",
                        k, bus_en, bus_we, bus_addr, bus_wdata, bus_wstrb);
            end
         end else if (bus_en !== 1'b0 || bus_we !== 1'b0 || bus_wstrb !== 4'h0 || hold_mem !== 1'b0) begin
            errors++;
            $display("FAIL store_end en %b we %b wstrb %h hold %b required 0 0 0 0",
                     bus_en, bus_we, bus_wstrb, hold_mem);
         end
      end
      mem_req = 1'b0; mem_we = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      int n = cyc;
      if_addr = 32'h300; if_req = 1'b1;
      mem_we = 1'b0; mem_addr = 32'h4000; mem_wstrb = 4'h0; mem_req = 1'b1;
      for (int k = 0; k < 4; k++) mem_q.push_back('{model(32'h4000), n + 3 + 3 * k});
      if_q.push_back('{model(32'h300), n + 15});
      mem_q.push_back('{model(32'h4000), n + 18});
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (k == 1 || k == 4 || k == 7 || k == 10 || k == 16) begin
            checks++;
            if (bus_en !== 1'b1 || bus_addr !== 32'h4000) begin
               errors++;
               $display("FAIL starve_mem_grant k %0d en %b addr %h required 1 00004000", k, bus_en, bus_addr);
            end
         end
         if (k == 13) begin
            checks++;
            if (bus_en !== 1'b1 || bus_addr !== 32'h300) begin
               errors++;
               $display("FAIL starve_if_forced en %b addr %h required 1 00000300", bus_en, bus_addr);
            end
         end
         if (k == 15) if_req = 1'b0;
         if (k == 18) mem_req = 1'b0;
      end
      tick();
   endtask

   task automatic test_latency1();
      int n = cyc;
      d1_if_addr = 32'h500; d1_if_req = 1'b1;
      d1_q.push_back('{model(32'h500), n + 2});
      d1_q.push_back('{model(32'h504), n + 4});
      d1_q.push_back('{model(32'h508), n + 6});
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1 || k == 3) begin
            checks++;
            if (d1_bus_en !== 1'b1 || d1_bus_addr !== ((k == 1) ? 32'h500 : 32'h504)) begin
               errors++;
               $display("FAIL lat1_bus k %0d en %b addr %h required 1 and addr %h",
                        k, d1_bus_en, d1_bus_addr, (k == 1) ? 32'h500 : 32'h504);
            end
         end
         if (k == 2) begin
            checks++;
            if (d1_bus_en !== 1'b0) begin
               errors++; $display("FAIL lat1_bus_off en %b required 0", d1_bus_en);
            end
            d1_if_addr = 32'h504;
         end
         if (k == 4) d1_if_addr = 32'h508;
         if (k == 6) d1_if_req = 1'b0;
      end
      tick();
   endtask

   task automatic test_reset_mid();
      mem_we = 1'b0; mem_addr = 32'h6000; mem_req = 1'b1;
      tick();
      checks++;
      if (bus_en !== 1'b1 || bus_addr !== 32'h6000) begin
         errors++; $display("FAIL rst_mid_start en %b addr %h required 1 00006000", bus_en, bus_addr);
      end
      tick();
      reset = 1'b1; mem_req = 1'b0;
      tick();
      checks++;
      if ({bus_en, bus_we, bus_addr, bus_wdata, bus_wstrb, if_ack, mem_ack, if_rdata, mem_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs en %b addr %h ack %b rdata %h required all zero",
                  bus_en, bus_addr, mem_ack, mem_rdata);
      end
      reset = 1'b0;
      tick();
      mem_req = 1'b1;
      mem_q.push_back('{model(32'h6000), cyc + 3});
      repeat (3) tick();
      checks++;
      if (mem_ack !== 1'b1 || mem_rdata !== model(32'h6000)) begin
         errors++;
         $display("FAIL rst_mid_fresh ack %b rdata %h required 1 %h", mem_ack, mem_rdata, model(32'h6000));
      end
      mem_req = 1'b0;
      tick();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_if_read();
      test_simultaneous();
      test_store();
      test_starvation();
      test_latency1();
      test_reset_mid();
      repeat (3) tick();
      checks++;
      if (if_q.size() != 0 || mem_q.size() != 0 || d1_q.size() != 0) begin
         errors++;
         $display("FAIL missing_acks pending if %0d mem %0d d1 %0d required 0 0 0",
                  if_q.size(), mem_q.size(), d1_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
